// File: rtl/mod_cfg_pkg.sv
// Shared definitions for the key-driven modulation parameter controller:
// mode encodings, update FSM states, event bit positions and default widths.
package mod_cfg_pkg;

  typedef enum logic [1:0] {
    MODE_ASK = 2'd0,
    MODE_FSK = 2'd1,
    MODE_PSK = 2'd2
  } mode_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_APPLY = 1'b1
  } upd_state_e;

  localparam int EV_MODE = 0;
  localparam int EV_UP   = 1;
  localparam int EV_DOWN = 2;

  localparam int DEF_NKEY    = 3;
  localparam int DEF_FW      = 2;
  localparam int DEF_NMODE   = 3;
  localparam int DEF_DEB_CYC = 20;

  // Mode register width; a single-bit field is kept even for one or two modes.
  function automatic int mode_width(input int nmode);
    return (nmode <= 2) ? 1 : $clog2(nmode);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One raw active-low key: 2-FF synchroniser, mismatch counter and a registered
// one-cycle press pulse on the debounced 1->0 transition.
module key_debounce #(
  parameter int DEB_CYC = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic level,
  output logic press
);

  localparam int CW = (DEB_CYC < 2) ? 1 : $clog2(DEB_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYC - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
    end
  end

  // Any agreement with the current level restarts the count, so only an
  // uninterrupted run of DEB_CYC differing samples flips the level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
        press <= level;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mod_param_ctrl.sv
// Key-driven modulation parameter controller: debounced key presses and
// auto-repeat step the modulation mode and carrier frequency code.
module mod_param_ctrl
  import mod_cfg_pkg::*;
#(
  parameter  int NKEY       = DEF_NKEY,
  parameter  int FW         = DEF_FW,
  parameter  int FREQ_MAX   = 3,
  parameter  int FREQ_RST   = 1,
  parameter  int NMODE      = DEF_NMODE,
  parameter  int DEB_CYC    = DEF_DEB_CYC,
  parameter  int REPEAT_CYC = 0,
  localparam int MW         = mode_width(NMODE)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NKEY-1:0] key,
  input  logic            wrap_en,
  input  logic            cfg_lock,
  output logic [FW-1:0]   freq_code,
  output logic [MW-1:0]   mod_mode,
  output logic            cfg_valid
);

  localparam logic [FW-1:0] F_MAX  = FW'(FREQ_MAX);
  localparam logic [FW-1:0] F_RST  = FW'(FREQ_RST);
  localparam logic [MW-1:0] M_LAST = MW'(NMODE - 1);

  logic [NKEY-1:0] level;
  logic [NKEY-1:0] press;
  logic [2:1]      rep_ev;
  logic [2:0]      ev_q;
  logic [2:0]      pend;
  logic            pend_valid;
  logic [2:0]      src;
  logic [FW-1:0]   next_freq;
  logic [MW-1:0]   next_mode;
  upd_state_e      state;

  for (genvar i = 0; i < NKEY; i++) begin : g_key
    key_debounce #(
      .DEB_CYC(DEB_CYC)
    ) u_deb (
      .clk    (clk),
      .rst_n  (rst_n),
      .key_raw(key[i]),
      .level  (level[i]),
      .press  (press[i])
    );
  end

  logic unused_mode_level;
  assign unused_mode_level = level[EV_MODE];

  if (NKEY > 3) begin : g_extra_keys
    logic unused_extra;
    assign unused_extra = ^{level[NKEY-1:3], press[NKEY-1:3]};
  end

  // One shared repeat counter for both step keys; any level change on either
  // key (new press or release) restarts the period.
  if (REPEAT_CYC > 0) begin : g_rep
    localparam int RW = (REPEAT_CYC < 2) ? 1 : $clog2(REPEAT_CYC);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYC - 1);

    logic [RW-1:0] rep_cnt;
    logic [2:1]    level_q;
    logic          held;
    logic          rep_clr;

    assign held    = ~&level[2:1];
    assign rep_clr = !held || (level[2:1] != level_q);
    assign rep_ev  = (held && rep_cnt == REP_LAST) ? ~level[2:1] : 2'b00;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rep_cnt <= '0;
        level_q <= 2'b11;
      end else begin
        level_q <= level[2:1];
        if (rep_clr || rep_cnt == REP_LAST) rep_cnt <= '0;
        else                                rep_cnt <= rep_cnt + 1'b1;
      end
    end
  end else begin : g_norep
    assign rep_ev = 2'b00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ev_q <= '0;
    else        ev_q <= press[2:0] | {rep_ev, 1'b0};
  end

  assign src = pend_valid ? pend : ev_q;

  // Lowest set event wins; mode+up together restores the defaults.
  always_comb begin
    next_freq = freq_code;
    next_mode = mod_mode;
    if (src[EV_MODE] && src[EV_UP]) begin
      next_freq = F_RST;
      next_mode = MW'(MODE_ASK);
    end else if (src[EV_MODE]) begin
      next_mode = (mod_mode == M_LAST) ? '0 : mod_mode + 1'b1;
    end else if (src[EV_UP]) begin
      if (freq_code == F_MAX) next_freq = wrap_en ? '0 : F_MAX;
      else                    next_freq = freq_code + 1'b1;
    end else if (src[EV_DOWN]) begin
      if (freq_code == '0) next_freq = wrap_en ? F_MAX : '0;
      else                 next_freq = freq_code - 1'b1;
    end
  end

  // Events landing during APPLY wait in a single pending slot, newest kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      freq_code  <= F_RST;
      mod_mode   <= MW'(MODE_ASK);
      cfg_valid  <= 1'b0;
      pend       <= '0;
      pend_valid <= 1'b0;
    end else begin
      cfg_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cfg_lock) begin
            pend_valid <= 1'b0;
          end else if (pend_valid || (|ev_q)) begin
            freq_code <= next_freq;
            mod_mode  <= next_mode;
            cfg_valid <= 1'b1;
            state     <= ST_APPLY;
            if (pend_valid) begin
              pend       <= ev_q;
              pend_valid <= |ev_q;
            end
          end
        end
        ST_APPLY: begin
          state <= ST_IDLE;
          if (cfg_lock) begin
            pend_valid <= 1'b0;
          end else if (|ev_q) begin
            pend       <= ev_q;
            pend_valid <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_param_ctrl.sv
// Bench for mod_param_ctrl: directed key sequences with literal expectations
// plus a cycle-by-cycle comparison against a behavioural model.
module tb_mod_param_ctrl;

  localparam int DEB   = 20;
  localparam int REP   = 50;
  localparam int FMAX  = 3;
  localparam int FRST  = 1;
  localparam int NMODE = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] key = 3'b111;
  logic       wrap_en = 1'b1;
  logic       cfg_lock = 1'b0;
  logic [1:0] freq_code;
  logic [1:0] mod_mode;
  logic       cfg_valid;

  int checks = 0;
  int errors = 0;
  int pulses;
  int lat;
  int vq[$];

  mod_param_ctrl #(
    .NKEY(3), .FW(2), .FREQ_MAX(FMAX), .FREQ_RST(FRST),
    .NMODE(NMODE), .DEB_CYC(DEB), .REPEAT_CYC(REP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key(key), .wrap_en(wrap_en), .cfg_lock(cfg_lock),
    .freq_code(freq_code), .mod_mode(mod_mode), .cfg_valid(cfg_valid)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: debounce as "last DEB synchronised samples all differ",
  // repeats as multiples of REP after the latest step-key level change.
  int  m_freq, m_mode, cyc, ref_cyc;
  bit  m_valid, pend_v, fany_prev, all_diff, nv;
  bit  [2:0] e_reg, pend, flow_prev, flow, rep;
  bit  lvl [0:2];
  bit  hist [0:2][0:DEB];

  function automatic void modelApply(input bit [2:0] e);
    if (e[0] && e[1]) begin
      m_freq = FRST;
      m_mode = 0;
    end else if (e[0]) m_mode = (m_mode + 1) % NMODE;
    else if (e[1]) m_freq = wrap_en ? (m_freq + 1) % (FMAX + 1) : ((m_freq + 1 > FMAX) ? FMAX : m_freq + 1);
    else if (e[2]) m_freq = wrap_en ? (m_freq + FMAX) % (FMAX + 1) : ((m_freq == 0) ? 0 : m_freq - 1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_freq = FRST; m_mode = 0; m_valid = 0; pend_v = 0; pend = 0;
      e_reg = 0; flow_prev = 0; fany_prev = 0; cyc = 0; ref_cyc = 0;
      for (int k = 0; k < 3; k++) begin
        lvl[k] = 1;
        for (int j = 0; j <= DEB; j++) hist[k][j] = 1;
      end
    end else begin
      cyc++;
      nv = 0;
      if (cfg_lock) pend_v = 0;
      else if (m_valid) begin
        if (e_reg != 0) begin pend = e_reg; pend_v = 1; end
      end else if (pend_v) begin
        modelApply(pend); nv = 1;
        if (e_reg != 0) pend = e_reg; else pend_v = 0;
      end else if (e_reg != 0) begin
        modelApply(e_reg); nv = 1;
      end
      m_valid = nv;
      rep = 0;
      for (int k = 1; k < 3; k++)
        if (!lvl[k] && cyc > ref_cyc && (cyc - ref_cyc) % REP == 0) rep[k] = 1;
      e_reg = flow_prev | rep;
      if (fany_prev) ref_cyc = cyc;
      flow = 0; fany_prev = 0;
      for (int k = 0; k < 3; k++) begin
        all_diff = 1;
        for (int j = 1; j <= DEB; j++) if (hist[k][j] == lvl[k]) all_diff = 0;
        if (all_diff) begin
          lvl[k] = !lvl[k];
          if (!lvl[k]) flow[k] = 1;
          if (k > 0) fany_prev = 1;
        end
      end
      flow_prev = flow;
      for (int k = 0; k < 3; k++) begin
        for (int j = DEB; j > 0; j--) hist[k][j] = hist[k][j-1];
        hist[k][0] = key[k];
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("model_freq", int'(freq_code), m_freq);
      checkOutput("model_mode", int'(mod_mode), m_mode);
      checkOutput("model_valid", int'(cfg_valid), int'(m_valid));
    end
  end

  task automatic applyStimulus(input logic [2:0] mask, input int hold);
    pulses = 0; lat = 0; vq.delete();
    @(negedge clk);
    key = key & ~mask;
    for (int i = 1; i <= hold; i++) begin
      @(negedge clk);
      if (cfg_valid) begin
        pulses++;
        if (lat == 0) lat = i;
        vq.push_back(int'(freq_code));
      end
    end
    key = key | mask;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cfg_valid) begin pulses++; vq.push_back(int'(freq_code)); end
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int seen;
    repeat (3) @(negedge clk);
    checkOutput("reset_freq", int'(freq_code), 1);
    checkOutput("reset_mode", int'(mod_mode), 0);
    checkOutput("reset_valid", int'(cfg_valid), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("[TB] single press with latency");
    applyStimulus(3'b010, 30);
    checkOutput("press_latency", lat, 24);
    checkOutput("press_pulses", pulses, 1);
    checkOutput("press_freq", int'(freq_code), 2);

    $display("[TB] bounce rejection");
    pulses = 0;
    for (int r = 0; r < 3; r++) begin
      key[1] = 1'b0;
      repeat (10) begin @(negedge clk); if (cfg_valid) pulses++; end
      key[1] = 1'b1;
      repeat (10) begin @(negedge clk); if (cfg_valid) pulses++; end
    end
    repeat (30) begin @(negedge clk); if (cfg_valid) pulses++; end
    checkOutput("bounce_pulses", pulses, 0);
    checkOutput("bounce_freq", int'(freq_code), 2);

    $display("[TB] wrap and saturate");
    applyStimulus(3'b010, 30);
    applyStimulus(3'b010, 30);
    checkOutput("wrap_up_freq", int'(freq_code), 0);
    wrap_en = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(3'b010, 30);
    applyStimulus(3'b010, 30);
    checkOutput("sat_up_freq", int'(freq_code), 3);
    checkOutput("sat_up_pulses", pulses, 1);
    wrap_en = 1'b1;
    applyStimulus(3'b010, 30);
    applyStimulus(3'b100, 30);
    checkOutput("wrap_down_freq", int'(freq_code), 3);

    $display("[TB] mode cycling and defaults");
    applyStimulus(3'b001, 30); checkOutput("mode_1", int'(mod_mode), 1);
    applyStimulus(3'b001, 30); checkOutput("mode_2", int'(mod_mode), 2);
    applyStimulus(3'b001, 30); checkOutput("mode_3", int'(mod_mode), 0);
    applyStimulus(3'b001, 30); checkOutput("mode_4", int'(mod_mode), 1);
    applyStimulus(3'b011, 30);
    checkOutput("defaults_freq", int'(freq_code), 1);
    checkOutput("defaults_mode", int'(mod_mode), 0);

    $display("[TB] auto-repeat down");
    applyStimulus(3'b010, 30);
    applyStimulus(3'b010, 30);
    wrap_en = 1'b0;
    applyStimulus(3'b100, 140);
    checkOutput("repeat_pulses", pulses, 3);
    checkOutput("repeat_count", vq.size(), 3);
    if (vq.size() == 3) begin
      checkOutput("repeat_v0", vq[0], 2);
      checkOutput("repeat_v1", vq[1], 1);
      checkOutput("repeat_v2", vq[2], 0);
    end
    checkOutput("repeat_final", int'(freq_code), 0);

    $display("[TB] configuration lock");
    cfg_lock = 1'b1;
    applyStimulus(3'b010, 30);
    checkOutput("lock_pulses", pulses, 0);
    checkOutput("lock_freq", int'(freq_code), 0);
    cfg_lock = 1'b0;
    applyStimulus(3'b010, 30);
    checkOutput("unlock_freq", int'(freq_code), 1);
    applyStimulus(3'b001, 30);
    checkOutput("premid_mode", int'(mod_mode), 1);

    $display("[TB] reset during APPLY");
    @(negedge clk);
    key[1] = 1'b0;
    seen = 0;
    for (int i = 0; i < 40 && seen == 0; i++) begin
      @(negedge clk);
      if (cfg_valid) seen = 1;
    end
    checkOutput("midreset_seen", seen, 1);
    #2 rst_n = 1'b0;
    key[1] = 1'b1;
    #1;
    checkOutput("midreset_freq", int'(freq_code), 1);
    checkOutput("midreset_mode", int'(mod_mode), 0);
    checkOutput("midreset_valid", int'(cfg_valid), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
